// File: rtl/ppu_pkg.sv
// Shared PPU types and constants: OAM scan states, OAM base, Y offset,
// sprite heights and the 9-bit Y-hit helper used by the line scanner.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_Y,
    WAIT_Y,
    REQ_X,
    WAIT_X,
    FINISH
  } scan_state_t;

  localparam logic [15:0] OAM_BASE_DEF = 16'hFE00;
  localparam logic [8:0]  Y_OFS        = 9'd16;
  localparam logic [8:0]  H_SHORT      = 9'd8;
  localparam logic [8:0]  H_TALL       = 9'd16;

  // 9-bit compare so neither ly+16 nor Y+H can wrap.
  function automatic logic y_hit(
    input logic [7:0] y,
    input logic [7:0] ly,
    input logic       tall
  );
    logic [8:0] row;
    logic [8:0] top;
    logic [8:0] h;
    row = {1'b0, ly} + Y_OFS;
    top = {1'b0, y};
    h   = tall ? H_TALL : H_SHORT;
    return (top <= row) && (row < top + h);
  endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// Per-line sprite buffer: one synchronous write port, one combinational
// read port. Ports: clk_in, we/wr_idx/wr_x/wr_id, rd_idx -> rd_x/rd_id.
module sprite_line_buffer #(
  parameter int DEPTH = 10,
  parameter int IDW   = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk_in,
  input  logic           we,
  input  logic [AW-1:0]  wr_idx,
  input  logic [7:0]     wr_x,
  input  logic [IDW-1:0] wr_id,
  input  logic [AW-1:0]  rd_idx,
  output logic [7:0]     rd_x,
  output logic [IDW-1:0] rd_id
);

  logic [7:0]     x_mem  [DEPTH];
  logic [IDW-1:0] id_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) begin
      x_mem[wr_idx]  <= wr_x;
      id_mem[wr_idx] <= wr_id;
    end
  end

  assign rd_x  = x_mem[rd_idx];
  assign rd_id = id_mem[rd_idx];

endmodule

// File: rtl/oam_line_scanner.sv
// OAM line scanner: walks OAM, buffers up to MAX_PER_LINE Y-hit sprites.
// Ports: clk_in, rst_in (async low), start_in, ly_in, tall_mode_in,
// OAM bus (oam_addr_out/oam_req_out/oam_data_in/oam_valid_in),
// buffer read (rd_idx_in -> rd_x_out/rd_id_out), count_out, busy_out,
// done_out. Macro OAM_SCAN_XFILTER_EN drops hits with X=0.
module oam_line_scanner
  import ppu_pkg::*;
#(
  parameter int          NUM_SPRITES  = 40,
  parameter int          MAX_PER_LINE = 10,
  parameter logic [15:0] OAM_BASE     = OAM_BASE_DEF,
  localparam int         NW = $clog2(NUM_SPRITES),
  localparam int         IW = $clog2(MAX_PER_LINE),
  localparam int         CW = $clog2(MAX_PER_LINE + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [7:0]    ly_in,
  input  logic          tall_mode_in,
  output logic [15:0]   oam_addr_out,
  output logic          oam_req_out,
  input  logic [7:0]    oam_data_in,
  input  logic          oam_valid_in,
  input  logic [IW-1:0] rd_idx_in,
  output logic [7:0]    rd_x_out,
  output logic [NW-1:0] rd_id_out,
  output logic [CW-1:0] count_out,
  output logic          busy_out,
  output logic          done_out
);

  scan_state_t   state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ly_q, ly_d;
  logic          tall_q, tall_d;
  logic          we;
  logic          keep_x;
  logic          last_n;
  logic          x_sel;

`ifdef OAM_SCAN_XFILTER_EN
  assign keep_x = (oam_data_in != 8'd0);
`else
  assign keep_x = 1'b1;
`endif

  assign last_n = (n_q == NW'(NUM_SPRITES - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      ly_q    <= '0;
      tall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      ly_q    <= ly_d;
      tall_q  <= tall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    ly_d    = ly_q;
    tall_d  = tall_q;
    we      = 1'b0;
    // start wins over everything, including a coincident valid
    if (start_in) begin
      state_d = REQ_Y;
      n_d     = '0;
      cnt_d   = '0;
      ly_d    = ly_in;
      tall_d  = tall_mode_in;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        REQ_Y: state_d = WAIT_Y;
        WAIT_Y: begin
          if (oam_valid_in) begin
            if (y_hit(oam_data_in, ly_q, tall_q)) begin
              state_d = REQ_X;
            end else if (last_n) begin
              state_d = FINISH;
            end else begin
              n_d     = n_q + 1'b1;
              state_d = REQ_Y;
            end
          end
        end
        REQ_X: state_d = WAIT_X;
        WAIT_X: begin
          if (oam_valid_in) begin
            we = keep_x;
            if (keep_x) cnt_d = cnt_q + 1'b1;
            if (last_n || cnt_d == CW'(MAX_PER_LINE)) begin
              state_d = FINISH;
            end else begin
              n_d     = n_q + 1'b1;
              state_d = REQ_Y;
            end
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign x_sel = (state_q == REQ_X) || (state_q == WAIT_X);

  assign oam_req_out  = (state_q == REQ_Y) || (state_q == REQ_X);
  assign oam_addr_out = OAM_BASE + (16'(n_q) << 2) + {15'd0, x_sel};
  assign busy_out     = (state_q != IDLE);
  assign done_out     = (state_q == FINISH);
  assign count_out    = cnt_q;

  sprite_line_buffer #(
    .DEPTH (MAX_PER_LINE),
    .IDW   (NW),
    .AW    (IW)
  ) u_buf (
    .clk_in (clk_in),
    .we     (we),
    .wr_idx (IW'(cnt_q)),
    .wr_x   (oam_data_in),
    .wr_id  (n_q),
    .rd_idx (rd_idx_in),
    .rd_x   (rd_x_out),
    .rd_id  (rd_id_out)
  );

endmodule
